xs3_bcd_decoder: RTL and testbench

Serial excess-3 to BCD decoder: the receive-side counterpart of the BCD-to-excess-3 converter. It accepts one excess-3 digit per handshake, removes the bias, and packs the digits most-significant-first into a DIGITS-wide BCD word. It flags any non-excess-3 code it receives. It sits between an excess-3 digit source and packed-BCD consumers such as a display or arithmetic unit, with valid/ready on both sides.

---
 rtl/xs3_bcd_decoder_if.sv | 27 ++
 rtl/xs3_bcd_decoder.sv | 115 +++++++++++
 tb/tb_xs3_bcd_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xs3_bcd_decoder_if.sv
// Handshake bundle for the serial excess-3 to packed-BCD decoder.
// The master side is the digit source and word consumer; the slave side is the decoder.
interface xs3_bcd_decoder_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_code;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [CW-1:0]         out_count;
    logic                  out_err;

    modport master (
        output in_valid, in_code, in_last, out_ready,
        input  in_ready, out_valid, out_bcd, out_count, out_err
    );

    modport slave (
        input  in_valid, in_code, in_last, out_ready,
        output in_ready, out_valid, out_bcd, out_count, out_err
    );
endinterface

// File: rtl/xs3_bcd_decoder.sv
// Serial excess-3 to BCD decoder.
// Accepts one excess-3 digit per handshake, removes the bias of 3 and shifts the
// digit into a DIGITS-wide packed BCD word, first digit most significant.
// A word is emitted on in_last or when DIGITS digits have been collected.
// Any code outside 3..12 sets a sticky per-word error flag.
// Optional build macro XS3_DEC_DROP_INVALID_EN: invalid codes are dropped
// (not stored, not counted). Without it they are stored as nibble 4'hF.
module xs3_bcd_decoder #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    xs3_bcd_decoder_if.slave   bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int W  = 4 * DIGITS;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    word, word_n;
    logic [CW-1:0]   count, count_n;
    logic            err, err_n;
    logic            valid_q;

    logic            code_ok;
    logic [3:0]      digit;
    logic [3:0]      nibble;
    logic            store;
    logic [W-1:0]    word_shift;
    logic [CW-1:0]   count_inc;

    // Valid excess-3 codes are 3..12; removing the bias is a 4-bit subtract.
    assign code_ok = (bus.in_code >= 4'd3) && (bus.in_code <= 4'd12);
    assign digit   = bus.in_code - 4'd3;

`ifdef XS3_DEC_DROP_INVALID_EN
    // Invalid codes still complete their handshake but leave the word untouched.
    assign store  = code_ok;
    assign nibble = digit;
`else
    // Invalid codes occupy a digit slot as the marker nibble F.
    assign store  = 1'b1;
    assign nibble = code_ok ? digit : 4'hF;
`endif

    // Shifting through a full-width zero-extended nibble keeps DIGITS=1 legal.
    assign word_shift = (word << 4) | W'(nibble);
    assign count_inc  = count + CW'(1);

    // The decoder only takes digits while no word is waiting on the output.
    assign bus.in_ready  = !valid_q;
    assign bus.out_valid = valid_q;
    assign bus.out_bcd   = word;
    assign bus.out_count = count;
    assign bus.out_err   = err;

    // Next-state logic: collect digits in ACCUM, hold the word in FULL until taken.
    always_comb begin
        state_n = state;
        word_n  = word;
        count_n = count;
        err_n   = err;
        case (state)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (store) begin
                        word_n  = word_shift;
                        count_n = count_inc;
                    end
                    if (!code_ok) begin
                        err_n = 1'b1;
                    end
                    if (bus.in_last || (count_n == CW'(DIGITS))) begin
                        state_n = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_n = ACCUM;
                    word_n  = '0;
                    count_n = '0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = ACCUM;
                word_n  = '0;
                count_n = '0;
                err_n   = 1'b0;
            end
        endcase
    end

    // State, word and flag registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            word    <= '0;
            count   <= '0;
            err     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            word    <= word_n;
            count   <= count_n;
            err     <= err_n;
            valid_q <= (state_n == FULL);
        end
    end
endmodule

// File: tb/tb_xs3_bcd_decoder.sv
// Self-checking bench for xs3_bcd_decoder: directed cases with literal
// expectations plus a randomized run compared against a digit-queue model.
module tb_xs3_bcd_decoder;
    localparam int DIGITS = 4;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int W      = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    xs3_bcd_decoder_if #(.DIGITS(DIGITS)) bus ();

    xs3_bcd_decoder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a word is just the list of digits received so far.
    bit mFull;
    bit mErr;
    int mDigits[$];

    function automatic logic [W-1:0] modelWord();
        logic [W-1:0] v;
        v = '0;
        foreach (mDigits[i]) v = v * 16 + W'(mDigits[i]);
        return v;
    endfunction

    task automatic modelReset();
        mFull = 1'b0;
        mErr  = 1'b0;
        mDigits.delete();
    endtask

    // Effect of the coming clock edge on the model, given the driven inputs.
    task automatic modelStep(input bit iv, input int code, input bit last, input bit ordy);
        bit ok;
        if (mFull) begin
            if (ordy) modelReset();
        end else if (iv) begin
            ok = (code >= 3) && (code <= 12);
            if (!ok) mErr = 1'b1;
`ifdef XS3_DEC_DROP_INVALID_EN
            if (ok) mDigits.push_back(code - 3);
`else
            mDigits.push_back(ok ? code - 3 : 15);
`endif
            if (last || mDigits.size() == DIGITS) mFull = 1'b1;
        end
    endtask

    task automatic checkValue(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model; word fields matter only when valid.
    task automatic checkOutput();
        checkValue("out_valid", longint'(bus.out_valid), longint'(mFull));
        checkValue("in_ready", longint'(bus.in_ready), longint'(!mFull));
        if (mFull) begin
            checkValue("out_bcd", longint'(bus.out_bcd), longint'(modelWord()));
            checkValue("out_count", longint'(bus.out_count), longint'(mDigits.size()));
            checkValue("out_err", longint'(bus.out_err), longint'(mErr));
        end
    endtask

    // One cycle: check at the falling edge, then drive inputs for the next rising edge.
    task automatic applyStimulus(input bit iv, input logic [3:0] code, input bit last, input bit ordy);
        checkOutput();
        bus.in_valid  = iv;
        bus.in_code   = code;
        bus.in_last   = last;
        bus.out_ready = ordy;
        modelStep(iv, int'(code), last, ordy);
        @(negedge clk);
    endtask

    task automatic checkWord(input string name, input logic [W-1:0] bcd, input int cnt, input bit e);
        checkValue({name, "_valid"}, longint'(bus.out_valid), 1);
        checkValue({name, "_bcd"}, longint'(bus.out_bcd), longint'(bcd));
        checkValue({name, "_count"}, longint'(bus.out_count), longint'(cnt));
        checkValue({name, "_err"}, longint'(bus.out_err), longint'(e));
    endtask

    task automatic checkCleared(input string name);
        checkValue({name, "_valid"}, longint'(bus.out_valid), 0);
        checkValue({name, "_bcd"}, longint'(bus.out_bcd), 0);
        checkValue({name, "_count"}, longint'(bus.out_count), 0);
        checkValue({name, "_err"}, longint'(bus.out_err), 0);
        checkValue({name, "_ready"}, longint'(bus.in_ready), 1);
    endtask

    initial begin
        bit         iv, last, ordy;
        logic [3:0] code;

        bus.in_valid  = 1'b0;
        bus.in_code   = 4'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        modelReset();

        // Reset held with random inputs.
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom);
            bus.in_code   = 4'($urandom);
            bus.in_last   = 1'($urandom);
            bus.out_ready = 1'($urandom);
            checkCleared("reset");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full word at maximum rate.
        applyStimulus(1, 4'h4, 0, 1);
        applyStimulus(1, 4'h5, 0, 1);
        applyStimulus(1, 4'h6, 0, 1);
        applyStimulus(1, 4'h7, 0, 1);
        checkWord("full", 16'h1234, 4, 0);
        applyStimulus(0, 4'h0, 0, 1);

        // Short word ended by in_last.
        applyStimulus(1, 4'hC, 0, 1);
        applyStimulus(1, 4'h3, 1, 1);
        checkWord("short", 16'h0090, 2, 0);
        applyStimulus(0, 4'h0, 0, 1);

        // Backpressure: word held while the consumer stalls.
        applyStimulus(1, 4'h4, 0, 0);
        applyStimulus(1, 4'h5, 0, 0);
        applyStimulus(1, 4'h6, 0, 0);
        applyStimulus(1, 4'h7, 0, 0);
        repeat (3) applyStimulus(1, 4'h8, 0, 0);
        checkValue("bp_in_ready", longint'(bus.in_ready), 0);
        checkWord("bp_hold", 16'h1234, 4, 0);
        applyStimulus(1, 4'h8, 0, 1);
        checkValue("bp_ready_back", longint'(bus.in_ready), 1);
        checkValue("bp_valid_low", longint'(bus.out_valid), 0);

        // Invalid code inside a word, then a clean word.
        applyStimulus(1, 4'h4, 0, 1);
        applyStimulus(1, 4'h1, 0, 1);
        applyStimulus(1, 4'h5, 1, 1);
`ifdef XS3_DEC_DROP_INVALID_EN
        checkWord("invalid", 16'h0012, 2, 1);
`else
        checkWord("invalid", 16'h01F2, 3, 1);
`endif
        applyStimulus(0, 4'h0, 0, 1);
        applyStimulus(1, 4'h4, 0, 1);
        applyStimulus(1, 4'h4, 1, 1);
        checkWord("after_invalid", 16'h0011, 2, 0);
        applyStimulus(0, 4'h0, 0, 1);

        // Reset mid-word.
        applyStimulus(1, 4'h9, 0, 1);
        applyStimulus(1, 4'hA, 0, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 4'h3, 0, 1);
        applyStimulus(1, 4'h4, 0, 1);
        applyStimulus(1, 4'h5, 0, 1);
        applyStimulus(1, 4'h6, 0, 1);
        checkWord("mid_reset", 16'h0123, 4, 0);
        applyStimulus(0, 4'h0, 0, 1);

        // Asynchronous reset in the middle of a clock phase while a word is held.
        applyStimulus(1, 4'h7, 0, 0);
        applyStimulus(1, 4'h8, 1, 0);
        applyStimulus(0, 4'h0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("async_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        repeat (3000) begin
            iv   = ($urandom_range(0, 3) != 0);
            code = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(3, 12));
            last = ($urandom_range(0, 4) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            applyStimulus(iv, code, last, ordy);
        end
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
